// File: rtl/tff_count_ctrl_pkg.sv
// Shared types and helpers for the T-flip-flop counter controller.
// The toggle-mask helper works on a fixed wide vector; callers cast to their own width.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int MASK_W = 32;

    // A bit toggles when every lower bit is 1 (up) or 0 (down): ripple-carry/borrow as a mask.
    function automatic logic [MASK_W-1:0] toggle_mask(input logic [MASK_W-1:0] cnt,
                                                      input logic dir);
        logic [MASK_W-1:0] t;
        t    = '0;
        t[0] = 1'b1;
        for (int i = 1; i < MASK_W; i++) begin
            t[i] = t[i-1] & ((dir == DIR_DOWN) ? ~cnt[i-1] : cnt[i-1]);
        end
        return t;
    endfunction

endpackage

// File: rtl/tff_count_ctrl_cell.sv
// Single T flip-flop cell of the counter bank; Q clears on synchronous reset.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic T,
    output logic Q,
    output logic Qb
);

    always_ff @(posedge clk) begin
        if (rst) Q <= 1'b0;
        else     Q <= Q ^ T;
    end

    assign Qb = ~Q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Up/down counter built from a bank of T cells; the FSM only ever steers toggle masks.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting; start launches a run, load_en overwrites the bank
//   RUN     | stepping toward the end value, honouring pause and abort
//   DONE    | one-cycle completion pulse, then back to IDLE
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             abort,
    input  logic             pause,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic             dir_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] init_val;
    logic [WIDTH-1:0] step_mask;
    logic [WIDTH-1:0] count_b_unused;
    logic             at_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            dir_q   <= DIR_UP;
            limit_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                dir_q   <= dir;
                limit_q <= limit;
            end
        end
    end

    assign end_val   = (dir_q == DIR_DOWN) ? '0 : limit_q;
    assign init_val  = (dir == DIR_DOWN) ? limit : '0;
    assign at_end    = (count == end_val);
    assign step_mask = WIDTH'(toggle_mask(MASK_W'(count), dir_q));

    always_comb begin
        state_nxt = state;
        t_vec     = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    t_vec     = count ^ init_val;
                    state_nxt = ST_RUN;
                end else if (load_en) begin
                    t_vec = count ^ load_val;
                end
            end
            ST_RUN: begin
                // End-compare precedes stepping, so the mask never wraps the bank.
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (at_end) begin
                    state_nxt = ST_DONE;
                end else if (!pause) begin
                    t_vec = step_mask;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);
    assign tc   = busy && at_end;
    assign done = (state == ST_DONE);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .T   (t_vec[i]),
            .Q   (count[i]),
            .Qb  (count_b_unused[i])
        );
    end

endmodule
